fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning PC and address width.
REQ-002 The block SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 Port clk, input, 1, is the clock; all state SHALL update on its rising edge.
REQ-004 Port rstn_i, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port redirect_i, input, 1, SHALL be the branch/jump taken pulse.
REQ-006 Port redirect_addr_i, input, WIDTH, SHALL be the redirect target, sampled only when redirect_i=1.
REQ-007 Port imem_req_o, output, 1, SHALL be the instruction memory request.
REQ-008 Port imem_addr_o, output, WIDTH, SHALL be the request address.
REQ-009 Port imem_gnt_i, input, 1, SHALL mean the request is accepted this cycle.
REQ-010 Port imem_rvalid_i, input, 1, SHALL mean the response data is valid this cycle.
REQ-011 Port imem_rdata_i, input, 32, SHALL be the response instruction word.
REQ-012 Port instr_valid_o, output, 1, SHALL mean the instruction is offered to decode.
REQ-013 Port instr_o, output, 32, SHALL be the offered instruction.
REQ-014 Port instr_pc_o, output, WIDTH, SHALL be the address of instr_o.
REQ-015 Port instr_ready_i, input, 1, SHALL mean decode accepts; a transfer occurs when instr_valid_o=1 and instr_ready_i=1.

Function
REQ-016 The FSM SHALL have four states, BOOT, FETCH, WAIT and HOLD, with at most one imem request outstanding.
REQ-017 BOOT: imem_req_o=0; the FSM SHALL move unconditionally to FETCH on the next edge.
REQ-018 FETCH: imem_req_o=1 and imem_addr_o=pc_q.
REQ-019 FETCH, imem_gnt_i=1: the FSM SHALL go to WAIT and latch fetch_pc<=pc_q.
REQ-020 FETCH, redirect_i=1 and gnt=0: pc_q<=redirect_addr_i and the FSM SHALL stay in FETCH; a redirect is the only case where the address may change while the request is ungranted.
REQ-021 FETCH, redirect_i=1 and gnt=1 in the same cycle: go to WAIT, set discard=1 and set pc_q<=redirect_addr_i.
REQ-022 WAIT: imem_req_o=0; rvalid is accepted in any cycle at or after gnt+1, with no timeout.
REQ-023 WAIT, rvalid=1 and discard=0 and redirect_i=0: instr_q<=imem_rdata_i, instr_pc<=fetch_pc, pc_q<=fetch_pc+4; go to HOLD.
REQ-024 WAIT, redirect_i=1 without rvalid: discard<=1 and pc_q<=redirect_addr_i; stay in WAIT.
REQ-025 WAIT, rvalid=1 with discard=1 or redirect_i=1: the response SHALL be dropped and the FSM goes to FETCH; discard<=0; pc_q holds the latest redirect target.
REQ-026 HOLD: instr_valid_o=1, and instr_o/instr_pc_o SHALL stay stable until transfer or redirect.
REQ-027 HOLD, redirect_i=1: this SHALL take priority over instr_ready_i; the instruction is dropped (instr_valid_o=0 next cycle), pc_q<=redirect_addr_i, go to FETCH.
REQ-028 HOLD, instr_ready_i=1 and no redirect: go to FETCH.
REQ-029 instr_valid_o SHALL be 1 only in HOLD; it is registered-state driven, with no combinational path from imem inputs.
REQ-030 Latency: gnt at cycle t and rvalid at t+1 SHALL give instr_valid_o=1 at t+2; steady state is one instruction per 3 cycles.
REQ-031 pc_q+4 SHALL wrap modulo 2^WIDTH (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 redirect_addr_i[1:0] SHALL be ignored and pc_q[1:0] SHALL be forced to 2'b00.
REQ-033 Back-to-back redirects SHALL each overwrite pc_q; the last one wins.

Reset
REQ-034 With rstn_i=0, at any time including mid-request, the block SHALL set state=BOOT, pc_q=RESET_ADDR, discard=0, imem_req_o=0, instr_valid_o=0, instr_o=0 and instr_pc_o=0.
REQ-035 After reset release, the first imem_req_o=1 SHALL occur in the second cycle, with imem_addr_o=RESET_ADDR.
REQ-036 An imem response arriving after a mid-request reset is outside the memory's contract; the block SHALL treat rvalid outside WAIT as ignored.

Verification
REQ-037 Reset release, gnt immediate, rvalid at +1, rdata=32'h0000_0013, ready=1 -> addresses 0x0, 0x4, 0x8, and instr_valid_o pulses with instr_pc_o=0x0 then 0x4.
REQ-038 rvalid delayed 5 cycles and ready held 0 for 3 cycles -> imem_req_o=0 during the wait, and instr_o/instr_pc_o are stable while instr_valid_o=1.
REQ-039 Redirect to 0x100 in WAIT before rvalid -> the response is dropped, instr_valid_o stays 0, and the next imem_addr_o=0x100.
REQ-040 Redirect to 0x203 while gnt=1 in FETCH -> the following response is dropped, and the next request uses address 0x200.
REQ-041 Redirect to 0x40 and ready=1 in the same HOLD cycle -> no transfer, instr_valid_o=0 next cycle, next address 0x40.
REQ-042 Redirect to 0xFFFF_FFFC, then a normal fetch -> the next address is 0x0000_0000; separately, asserting rstn_i=0 while in WAIT -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: single-outstanding instruction fetch sequencer.
// Issues one imem request at a time, holds the returned instruction for
// decode and follows branch/jump redirects, dropping any in-flight response
// that a redirect has made stale.
module fetch_seq #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_addr_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  input  logic             instr_ready_i
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Instruction addresses are word aligned; the low two bits are always zero.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));
  localparam logic [WIDTH-1:0] RESET_PC   = RESET_ADDR & ALIGN_MASK;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_fetch_pc;
  logic             r_discard;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_instr_pc;
  logic [WIDTH-1:0] w_redir_pc;

  assign w_redir_pc = redirect_addr_i & ALIGN_MASK;

  // All outputs come straight from registered state; no imem input reaches them.
  always_comb begin
    imem_req_o    = (r_state == S_FETCH);
    imem_addr_o   = r_pc;
    instr_valid_o = (r_state == S_HOLD);
    instr_o       = r_instr;
    instr_pc_o    = r_instr_pc;
  end

  // Fetch FSM with PC, in-flight address, discard flag and held instruction.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_fetch_pc <= '0;
      r_discard  <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_gnt_i) begin
            r_state    <= S_WAIT;
            r_fetch_pc <= r_pc;
            // Redirect in the grant cycle: the granted fetch is already stale.
            if (redirect_i) begin
              r_discard <= 1'b1;
              r_pc      <= w_redir_pc;
            end
          end else if (redirect_i) begin
            r_pc <= w_redir_pc;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (r_discard || redirect_i) begin
              r_state   <= S_FETCH;
              r_discard <= 1'b0;
              if (redirect_i) begin
                r_pc <= w_redir_pc;
              end
            end else begin
              r_state    <= S_HOLD;
              r_instr    <= imem_rdata_i;
              r_instr_pc <= r_fetch_pc;
              r_pc       <= r_fetch_pc + WIDTH'(4);
            end
          end else if (redirect_i) begin
            r_discard <= 1'b1;
            r_pc      <= w_redir_pc;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            r_state <= S_FETCH;
            r_pc    <= w_redir_pc;
          end else if (instr_ready_i) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed scenarios followed by randomized traffic. A memory
// responder and a transaction-level reference model queue the instructions
// that must reach decode; an independent monitor pops and compares them.
module tb_fetch_seq;

  localparam int unsigned W     = 32;
  localparam logic [31:0] RST_A = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  fetch_seq #(.WIDTH(W), .RESET_ADDR(RST_A)) dut (
    .clk             (clk),
    .rstn_i          (rstn_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Reference model: architectural next fetch address plus the one in-flight fetch.
  logic [31:0] m_next_pc;
  bit          m_outst;
  bit          m_live;
  logic [31:0] m_addr;
  int          m_age;

  bit          use_fixed;
  logic [31:0] fixed_data;

  logic        obs_req;
  logic        obs_valid;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;

  bit          e_req  [7] = '{1, 0, 0, 1, 0, 0, 1};
  bit          e_valid[7] = '{0, 0, 1, 0, 0, 1, 0};
  logic [31:0] e_addr [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h8};
  logic [31:0] e_pc   [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (use_fixed) return fixed_data;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic zero_inputs();
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    imem_gnt_i      = 1'b0;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = '0;
    instr_ready_i   = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1;
    rstn_i = 1'b0;
    zero_inputs();
    sb.delete();
    m_outst   = 1'b0;
    m_live    = 1'b0;
    m_age     = 0;
    m_next_pc = RST_A;
    #1;
    check("rst_req",       imem_req_o,    32'h0);
    check("rst_valid",     instr_valid_o, 32'h0);
    check("rst_instr",     instr_o,       32'h0);
    check("rst_instr_pc",  instr_pc_o,    32'h0);
    repeat (cycles) @(negedge clk);
    #1;
    rstn_i = 1'b1;
    check("boot_no_req", imem_req_o, 32'h0);
  endtask

  // One clock of stimulus: memory grants/responds only where legal, model advances.
  task automatic step(input bit g, input bit rv, input bit rd, input logic [31:0] ra, input bit rdy);
    exp_t e;
    @(negedge clk);
    obs_req   = imem_req_o;
    obs_addr  = imem_addr_o;
    obs_valid = instr_valid_o;
    obs_pc    = instr_pc_o;
    if (m_outst) m_age++;
    if (obs_req) begin
      check("req_while_outstanding", {31'b0, m_outst}, 32'h0);
      check("req_addr", obs_addr, m_next_pc);
    end
    imem_gnt_i      = g & obs_req;
    imem_rvalid_i   = rv & m_outst & (m_age >= 1);
    imem_rdata_i    = imem_rvalid_i ? mem_word(m_addr) : $urandom;
    redirect_i      = rd;
    redirect_addr_i = rd ? ra : $urandom;
    instr_ready_i   = rdy;
    if (imem_rvalid_i) begin
      if (m_live && !rd) begin
        e.pc  = m_addr;
        e.ins = mem_word(m_addr);
        sb.push_back(e);
        m_next_pc = m_addr + 32'd4;
      end
      m_outst = 1'b0;
    end
    if (imem_gnt_i) begin
      m_outst = 1'b1;
      m_live  = 1'b1;
      m_addr  = m_next_pc;
      m_age   = 0;
    end
    if (rd) begin
      m_next_pc = ra & 32'hFFFF_FFFC;
      m_live    = 1'b0;
    end
  endtask

  // Monitor: each new instruction offered to decode must match the queue head.
  initial begin
    bit          prev;
    logic [31:0] hold_pc;
    logic [31:0] hold_ins;
    exp_t        e;
    prev     = 1'b0;
    hold_pc  = '0;
    hold_ins = '0;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        prev = 1'b0;
      end else if (instr_valid_o) begin
        if (!prev) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_instr: got pc %h, expected no instruction at %0t", instr_pc_o, $time);
          end else begin
            e = sb.pop_front();
            check("instr_pc",   instr_pc_o, e.pc);
            check("instr_word", instr_o,    e.ins);
          end
          hold_pc  = instr_pc_o;
          hold_ins = instr_o;
        end else begin
          check("hold_pc_stable",    instr_pc_o, hold_pc);
          check("hold_instr_stable", instr_o,    hold_ins);
        end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] ra;
    rstn_i = 1'b0;
    zero_inputs();
    use_fixed  = 1'b1;
    fixed_data = 32'h0000_0013;
    do_reset(3);

    // Straight-line fetch: 0x0, 0x4, 0x8 with valid two cycles after each grant.
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 32'h0, 1);
      check("t1_req",   {31'b0, obs_req},   {31'b0, e_req[i]});
      check("t1_valid", {31'b0, obs_valid}, {31'b0, e_valid[i]});
      if (e_req[i])   check("t1_addr", obs_addr, e_addr[i]);
      if (e_valid[i]) check("t1_pc",   obs_pc,   e_pc[i]);
    end

    // Slow response (5 cycles) and decode stalled for 3 cycles.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 0);
      check("t2_req_idle", {31'b0, obs_req}, 32'h0);
    end
    step(0, 1, 0, 32'h0, 0);
    check("t2_req_idle", {31'b0, obs_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 0);
      check("t2_valid", {31'b0, obs_valid}, 32'h1);
      check("t2_pc",    obs_pc, 32'h8);
    end
    step(0, 0, 0, 32'h0, 1);
    check("t2_valid", {31'b0, obs_valid}, 32'h1);
    use_fixed = 1'b0;

    // Redirect while waiting: response dropped, next fetch at 0x100.
    step(1, 0, 0, 32'h0, 0);
    check("t3_addr", obs_addr, 32'hC);
    step(0, 0, 1, 32'h100, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    check("t3_valid", {31'b0, obs_valid}, 32'h0);
    check("t3_addr",  obs_addr, 32'h100);

    // Redirect in the grant cycle with unaligned target.
    step(1, 0, 1, 32'h203, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    check("t4_valid", {31'b0, obs_valid}, 32'h0);
    check("t4_addr",  obs_addr, 32'h200);

    // Redirect beats ready in HOLD.
    step(1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 0, 1, 32'h40, 1);
    check("t5_valid", {31'b0, obs_valid}, 32'h1);
    check("t5_pc",    obs_pc, 32'h200);
    step(0, 0, 0, 32'h0, 0);
    check("t5_valid_dropped", {31'b0, obs_valid}, 32'h0);
    check("t5_addr",  obs_addr, 32'h40);

    // PC wrap at the top of the address space, then reset mid-wait.
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 32'h0, 0);
    check("t6_addr_top", obs_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 1);
    check("t6_pc_top", obs_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 32'h0, 0);
    check("t6_addr_wrap", obs_addr, 32'h0);
    do_reset(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 3) begin
        do_reset(int'($urandom_range(3, 1)));
      end else begin
        ra = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        step($urandom_range(99) < 60, $urandom_range(99) < 50,
             $urandom_range(99) < 8, ra, $urandom_range(99) < 60);
      end
    end

    // Drain: every queued instruction must eventually be offered.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 32'h0, 1);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
